// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder (optional fault checks under DMEM_ERR_CHECK_EN)
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_rmask,
  input  logic [3:0]  req_wmask,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic        lat_rd, lat_wr;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_rmask, lat_wmask;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, enter_resp;
  logic        cur_rd, cur_wr, cur_err;
  logic [31:0] cur_addr, cur_wdata, wmask32;
  logic [3:0]  cur_rmask, cur_wmask;
  logic [IDX_W-1:0] word_idx;

  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  assign accept     = (state == S_IDLE) && (req_rd || req_wr);
  assign enter_resp = (state_next == S_RESP) && !rst;

  // With zero wait states RESP is entered on the accept edge, so use the live request.
  always_comb begin
    if (state == S_IDLE) begin
      cur_rd = req_rd;  cur_wr = req_wr;  cur_addr = req_addr;
      cur_wdata = req_wdata;  cur_rmask = req_rmask;  cur_wmask = req_wmask;
    end else begin
      cur_rd = lat_rd;  cur_wr = lat_wr;  cur_addr = lat_addr;
      cur_wdata = lat_wdata;  cur_rmask = lat_rmask;  cur_wmask = lat_wmask;
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  assign cur_err  = (cur_addr[1:0] != 2'b00) ||
                    ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) ||
                    (cur_rd && cur_wr);
  assign word_idx = cur_addr[IDX_W+1:2];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cur_addr[1:0];
  assign cur_err  = 1'b0;
  assign word_idx = IDX_W'(cur_addr[31:2] % 30'(DEPTH_WORDS));
`endif

  assign wmask32 = lanes(cur_wmask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_rd || req_wr) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wait_cnt <= 4'd1) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE) && !rst;
    resp_valid = (state == S_RESP) && !rst;
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_err   = resp_valid ? err_q : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (state == S_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      lat_rd    <= req_rd;
      lat_wr    <= req_wr;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_rmask <= req_rmask;
      lat_wmask <= req_wmask;
    end
  end

  // Array has no reset; a reset during WAIT suppresses enter_resp and so drops the store.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_wr && !cur_err) begin
      mem[word_idx] <= (mem[word_idx] & ~wmask32) | (cur_wdata & wmask32);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= (cur_rd && !cur_wr && !cur_err) ? (mem[word_idx] & lanes(cur_rmask)) : 32'h0;
      err_q   <= cur_err;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (WAIT_CYCLES=2 and 0 instances)
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int W     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_rd = 0, req_wr = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_rmask = 0, req_wmask = 0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        r1_rd = 0, r1_wr = 0;
  logic [31:0] r1_addr = 0, r1_wdata = 0;
  logic [3:0]  r1_rmask = 0, r1_wmask = 0;
  logic        r1_ready, r1_valid, r1_err;
  logic [31:0] r1_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut0 (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rmask(req_rmask), .req_wmask(req_wmask),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .req_rd(r1_rd), .req_wr(r1_wr), .req_addr(r1_addr),
    .req_wdata(r1_wdata), .req_rmask(r1_rmask), .req_wmask(r1_wmask),
    .req_ready(r1_ready), .resp_valid(r1_valid), .resp_rdata(r1_rdata), .resp_err(r1_err));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          check("resp_cycle", cyc, e.at);
        end
      end else begin
        check("idle_outputs", resp_rdata | {31'b0, resp_err}, 32'h0);
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
    req_rmask = rm; req_wmask = wm;
    sb.push_back('{exp_rdata, exp_err, cyc + 1 + W});
    @(posedge clk);
    #1 req_rd = 0; req_wr = 0;
  endtask

  task automatic issue1(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] m, input logic [31:0] exp_rdata);
    @(negedge clk);
    if (!r1_ready) check("w0_ready_before", 32'd0, 32'd1);
    r1_rd = rd; r1_wr = wr; r1_addr = addr; r1_wdata = wdata; r1_rmask = m; r1_wmask = m;
    @(posedge clk);
    #1 r1_rd = 0; r1_wr = 0;
    @(negedge clk);
    check("w0_valid_n1", {31'b0, r1_valid}, 32'd1);
    check("w0_ready_n1", {31'b0, r1_ready}, 32'd0);
    check("w0_rdata", r1_rdata, exp_rdata);
    @(negedge clk);
    check("w0_ready_n2", {31'b0, r1_ready}, 32'd1);
    check("w0_valid_n2", {31'b0, r1_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", {31'b0, req_ready}, 32'd0);
      check("rst_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_rdata_err", resp_rdata | {31'b0, resp_err}, 32'h0);
    end
    #1 rst = 0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);

    issue(0, 1, 32'h10, 32'hDEADBEEF, 4'h0, 4'hF, 32'h0, 0);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 4'h0, 32'hDEADBEEF, 0);
    issue(0, 1, 32'h10, 32'h0000AA00, 4'h0, 4'b0010, 32'h0, 0);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 4'h0, 32'hDEADAAEF, 0);
    issue(1, 0, 32'h10, 32'h0, 4'b0001, 4'h0, 32'h000000EF, 0);
    issue(1, 0, 32'h10, 32'h0, 4'b1010, 4'h0, 32'hDE00AA00, 0);
    issue(0, 1, 32'h10, 32'h12345678, 4'h0, 4'h0, 32'h0, 0);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 4'h0, 32'hDEADAAEF, 0);

`ifdef DMEM_ERR_CHECK_EN
    issue(0, 1, 32'h12, 32'h11111111, 4'h0, 4'hF, 32'h0, 1);
    issue(0, 1, DEPTH * 4, 32'h22222222, 4'h0, 4'hF, 32'h0, 1);
    issue(1, 1, 32'h10, 32'h33333333, 4'hF, 4'hF, 32'h0, 1);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 4'h0, 32'hDEADAAEF, 0);
`else
    issue(0, 1, 32'h12, 32'h11111111, 4'h0, 4'hF, 32'h0, 0);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 4'h0, 32'h11111111, 0);
    issue(0, 1, DEPTH * 4, 32'h22222222, 4'h0, 4'hF, 32'h0, 0);
    issue(1, 0, 32'h0, 32'h0, 4'hF, 4'h0, 32'h22222222, 0);
    issue(1, 1, 32'h4, 32'h33333333, 4'hF, 4'hF, 32'h0, 0);
    issue(1, 0, 32'h4, 32'h0, 4'hF, 4'h0, 32'h33333333, 0);
`endif

    // Abort a store to 0x20 with a reset pulse during its WAIT phase.
    issue(0, 1, 32'h20, 32'hAAAA5555, 4'h0, 4'hF, 32'h0, 0);
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_wr = 1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_wmask = 4'hF;
    @(posedge clk);
    #1 req_wr = 0;
    @(negedge clk);
    #1 rst = 1;
    #1 check("abort_rst_ready", {31'b0, req_ready}, 32'd0);
    check("abort_rst_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    #1 rst = 0;
    #1 check("abort_ready_after", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    issue(1, 0, 32'h20, 32'h0, 4'hF, 4'h0, 32'hAAAA5555, 0);

    issue1(0, 1, 32'h8, 32'hCAFEF00D, 4'hF, 32'h0);
    issue1(1, 0, 32'h8, 32'h0, 4'b1100, 32'hCAFE0000);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
